// File: rtl/mod_arith_pkg.sv
// Shared types and helpers for the sequential modular arithmetic blocks:
// FSM state encoding, minimum operand width and the single conditional subtract.
package mod_arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Widest supported residue; intermediates carry one extra bit.
    localparam int MAX_W = 16;

    typedef logic [MAX_W:0] wide_t;

    // Smallest W with 2^W >= m; returns MAX_W+1 when m is out of range.
    function automatic int mod_width(input int m);
        int w;
        w = MAX_W + 1;
        for (int i = MAX_W; i >= 1; i--) begin
            if ((32'd1 << i) >= m) begin
                w = i;
            end else begin
                w = w;
            end
        end
        return w;
    endfunction

    // Exact reduction of any x < 2*m into [0, m).
    function automatic wide_t cond_sub(input wide_t x, input wide_t m);
        wide_t r;
        if (x >= m) begin
            r = x - m;
        end else begin
            r = x;
        end
        return r;
    endfunction

endpackage

// File: rtl/mod_dbl_add_step.sv
// One MSB-first double-and-add step: acc_next = (2*acc + add_bit*a) mod MOD.
// With acc=0 and add_bit=1 it degenerates to a single reduction of a.
module mod_dbl_add_step
    import mod_arith_pkg::*;
#(
    parameter int MOD = 47,
    parameter int W   = mod_width(MOD)
) (
    input  logic [W-1:0] acc,
    input  logic [W-1:0] a,
    input  logic         add_bit,
    output logic [W-1:0] acc_next
);

    localparam wide_t MOD_WIDE = wide_t'(MOD);

    logic [W:0]   dbl_s;
    logic [W:0]   sum_s;
    logic [W-1:0] red_dbl_s;
    logic [W-1:0] red_sum_s;

    // Both operands are already reduced, so each sum is below 2*MOD and one subtract suffices.
    always_comb begin
        dbl_s     = {acc, 1'b0};
        red_dbl_s = W'(cond_sub(wide_t'(dbl_s), MOD_WIDE));
        sum_s     = {1'b0, red_dbl_s} + {1'b0, a};
        red_sum_s = W'(cond_sub(wide_t'(sum_s), MOD_WIDE));
        if (add_bit) begin
            acc_next = red_sum_s;
        end else begin
            acc_next = red_dbl_s;
        end
    end

endmodule

// File: rtl/mod_mul_seq.sv
// Sequential modular multiplier z = (a*b) mod MOD, one multiplier bit per cycle,
// valid/ready on both sides. Optional MOD_MUL_PREREDUCE_EN reduces operands on capture.
module mod_mul_seq
    import mod_arith_pkg::*;
#(
    parameter int MOD = 47,
    parameter int W   = mod_width(MOD)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_z
);

    localparam int CNT_W = (W > 32'sd1) ? $clog2(W) : 32'sd1;

    // Single conditional subtracts are only exact when every W-bit value is below 2*MOD.
    generate
        if (MOD < 32'sd2 || MOD > 32'sd65535 || W < 32'sd1 || W > MAX_W ||
            (64'd1 << W) >= 64'(32'sd2 * MOD)) begin : g_bad_param
            $error("mod_mul_seq: illegal MOD/W combination");
        end
    endgenerate

    state_e             state_r;
    state_e             state_nx_s;
    logic [W-1:0]       a_r;
    logic [W-1:0]       a_nx_s;
    logic [W-1:0]       b_r;
    logic [W-1:0]       b_nx_s;
    logic [W-1:0]       acc_r;
    logic [W-1:0]       acc_nx_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   cnt_nx_s;
    logic               in_ready_r;
    logic               in_ready_nx_s;
    logic               out_valid_r;
    logic               out_valid_nx_s;
    logic [W-1:0]       out_z_r;
    logic [W-1:0]       out_z_nx_s;
    logic [W-1:0]       step_s;
    logic               bit_s;
    logic [W-1:0]       a_cap_s;
    logic [W-1:0]       b_cap_s;

    assign bit_s = b_r[cnt_r];

    mod_dbl_add_step #(.MOD(MOD), .W(W)) u_step (
        .acc      (acc_r),
        .a        (a_r),
        .add_bit  (bit_s),
        .acc_next (step_s)
    );

`ifdef MOD_MUL_PREREDUCE_EN
    mod_dbl_add_step #(.MOD(MOD), .W(W)) u_pre_a (
        .acc      ({W{1'b0}}),
        .a        (in_a),
        .add_bit  (1'b1),
        .acc_next (a_cap_s)
    );

    mod_dbl_add_step #(.MOD(MOD), .W(W)) u_pre_b (
        .acc      ({W{1'b0}}),
        .a        (in_b),
        .add_bit  (1'b1),
        .acc_next (b_cap_s)
    );
`else
    assign a_cap_s = in_a;
    assign b_cap_s = in_b;
`endif

    // Next-state and next-register values for the IDLE/RUN/DONE handshake FSM.
    always_comb begin
        state_nx_s     = state_r;
        a_nx_s         = a_r;
        b_nx_s         = b_r;
        acc_nx_s       = acc_r;
        cnt_nx_s       = cnt_r;
        in_ready_nx_s  = in_ready_r;
        out_valid_nx_s = out_valid_r;
        out_z_nx_s     = out_z_r;
        case (state_r)
            IDLE: begin
                if (in_valid && in_ready_r) begin
                    state_nx_s    = RUN;
                    a_nx_s        = a_cap_s;
                    b_nx_s        = b_cap_s;
                    acc_nx_s      = {W{1'b0}};
                    cnt_nx_s      = CNT_W'(W - 32'sd1);
                    in_ready_nx_s = 1'b0;
                end else begin
                    in_ready_nx_s = 1'b1;
                end
            end
            RUN: begin
                acc_nx_s = step_s;
                if (cnt_r == {CNT_W{1'b0}}) begin
                    state_nx_s     = DONE;
                    out_valid_nx_s = 1'b1;
                    out_z_nx_s     = step_s;
                end else begin
                    cnt_nx_s = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nx_s     = IDLE;
                    out_valid_nx_s = 1'b0;
                    in_ready_nx_s  = 1'b1;
                end else begin
                    out_valid_nx_s = 1'b1;
                end
            end
            default: begin
                state_nx_s     = IDLE;
                a_nx_s         = {W{1'b0}};
                b_nx_s         = {W{1'b0}};
                acc_nx_s       = {W{1'b0}};
                cnt_nx_s       = {CNT_W{1'b0}};
                in_ready_nx_s  = 1'b1;
                out_valid_nx_s = 1'b0;
                out_z_nx_s     = {W{1'b0}};
            end
        endcase
    end

    // State and datapath registers; reset discards any in-flight product.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            a_r         <= {W{1'b0}};
            b_r         <= {W{1'b0}};
            acc_r       <= {W{1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            out_z_r     <= {W{1'b0}};
        end else begin
            state_r     <= state_nx_s;
            a_r         <= a_nx_s;
            b_r         <= b_nx_s;
            acc_r       <= acc_nx_s;
            cnt_r       <= cnt_nx_s;
            in_ready_r  <= in_ready_nx_s;
            out_valid_r <= out_valid_nx_s;
            out_z_r     <= out_z_nx_s;
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_z     = out_z_r;

endmodule
